// File: rtl/memlog_dumper.sv
// rtl/memlog_dumper.sv - MEMLog readout: walks every log word and streams its bytes MSB first
//
// Purpose: once the capture log reports full, a start request reads log words
//   0 .. 2^BRAM_ADDR_WIDTH-1. Each word is split into bytes, most significant
//   byte first, and offered on a valid/ready byte stream. A done pulse closes
//   the dump. All outputs are registered.
// Ports:
//   clk                  in   rising-edge clock
//   i_rst                in   asynchronous active-low reset
//   i_start              in   dump request, honoured only while idle
//   i_mem_full           in   log full flag, checked only while idle
//   o_read_log           out  one-cycle pulse switching the log into read mode
//   o_addr_log_to_mem    out  log read address
//   i_data_log_from_mem  in   log read data, RD_LATENCY cycles after the address
//   o_tx_data            out  byte to the sink
//   o_tx_valid           out  o_tx_data valid
//   i_tx_ready           in   sink accepts the byte when high together with o_tx_valid
//   o_busy               out  high whenever a dump is in progress
//   o_done               out  one-cycle pulse after the last byte is accepted
//   o_err                out  one-cycle pulse when a start is rejected (log not full)
module memlog_dumper #(
   parameter int BRAM_ADDR_WIDTH = 15,
   parameter int BRAM_DATA_WIDTH = 16,
   parameter int RD_LATENCY      = 1
) (
   input  logic                       clk,
   input  logic                       i_rst,
   input  logic                       i_start,
   input  logic                       i_mem_full,
   output logic                       o_read_log,
   output logic [BRAM_ADDR_WIDTH-1:0] o_addr_log_to_mem,
   input  logic [BRAM_DATA_WIDTH-1:0] i_data_log_from_mem,
   output logic [7:0]                 o_tx_data,
   output logic                       o_tx_valid,
   input  logic                       i_tx_ready,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_err
);

   localparam int NBYTES = BRAM_DATA_WIDTH / 8;
   localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int LATW   = $clog2(RD_LATENCY + 1);

   localparam logic [BRAM_ADDR_WIDTH-1:0] LAST_ADDR = '1;
   localparam logic [IDXW-1:0]            TOP_IDX   = IDXW'(NBYTES - 1);
   localparam logic [LATW-1:0]            LAT_END   = LATW'(RD_LATENCY);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_FETCH,
      S_SEND,
      S_NEXT,
      S_DONE
   } state_t;

   state_t                     state;
   logic [LATW-1:0]            lat_cnt;
   logic [IDXW-1:0]            byte_idx;
   logic [BRAM_DATA_WIDTH-1:0] word_q;
   logic [IDXW-1:0]            nxt_idx;

   assign nxt_idx = byte_idx - 1'b1;

   always_ff @(posedge clk or negedge i_rst) begin
      if (!i_rst) begin
         state             <= S_IDLE;
         lat_cnt           <= '0;
         byte_idx          <= '0;
         word_q            <= '0;
         o_read_log        <= 1'b0;
         o_addr_log_to_mem <= '0;
         o_tx_data         <= '0;
         o_tx_valid        <= 1'b0;
         o_busy            <= 1'b0;
         o_done            <= 1'b0;
         o_err             <= 1'b0;
      end else begin
         // Pulse outputs default low; states raise them for one cycle.
         o_read_log <= 1'b0;
         o_done     <= 1'b0;
         o_err      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_start && i_mem_full) begin
                  state      <= S_ARM;
                  o_read_log <= 1'b1;
                  o_busy     <= 1'b1;
               end else if (i_start) begin
                  o_err <= 1'b1;
               end
            end
            S_ARM: begin
               o_addr_log_to_mem <= '0;
               lat_cnt           <= '0;
               state             <= S_FETCH;
            end
            S_FETCH: begin
               // Address has been stable for RD_LATENCY cycles: data is valid now.
               if (lat_cnt == LAT_END) begin
                  word_q     <= i_data_log_from_mem;
                  o_tx_data  <= i_data_log_from_mem[BRAM_DATA_WIDTH-1 -: 8];
                  o_tx_valid <= 1'b1;
                  byte_idx   <= TOP_IDX;
                  state      <= S_SEND;
               end else begin
                  lat_cnt <= lat_cnt + 1'b1;
               end
            end
            S_SEND: begin
               // o_tx_valid is high for the whole of SEND, so ready alone marks a transfer.
               if (i_tx_ready) begin
                  if (byte_idx == '0) begin
                     o_tx_valid <= 1'b0;
                     state      <= S_NEXT;
                  end else begin
                     byte_idx  <= nxt_idx;
                     o_tx_data <= word_q[nxt_idx*8 +: 8];
                  end
               end
            end
            S_NEXT: begin
               if (o_addr_log_to_mem == LAST_ADDR) begin
                  o_done <= 1'b1;
                  state  <= S_DONE;
               end else begin
                  o_addr_log_to_mem <= o_addr_log_to_mem + 1'b1;
                  lat_cnt           <= '0;
                  state             <= S_FETCH;
               end
            end
            S_DONE: begin
               o_addr_log_to_mem <= '0;
               o_busy            <= 1'b0;
               state             <= S_IDLE;
            end
            default: begin
               state  <= S_IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memlog_dumper.sv
// tb/tb_memlog_dumper.sv - directed bench for memlog_dumper at read latencies 1 and 2
module tb_memlog_dumper;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, start, mem_full, tx_ready, sel;
   logic start1, start2;
   assign start1 = start & ~sel;
   assign start2 = start & sel;

   logic        read1, valid1, busy1, done1, err1;
   logic [3:0]  addr1;
   logic [7:0]  txd1;
   logic [15:0] rd1_q;

   logic        read2, valid2, busy2, done2, err2;
   logic [3:0]  addr2;
   logic [7:0]  txd2;
   logic [15:0] rd2_p, rd2_q;

   memlog_dumper #(.BRAM_ADDR_WIDTH(4), .BRAM_DATA_WIDTH(16), .RD_LATENCY(1)) dut (
      .clk(clk), .i_rst(rst_n), .i_start(start1), .i_mem_full(mem_full),
      .o_read_log(read1), .o_addr_log_to_mem(addr1), .i_data_log_from_mem(rd1_q),
      .o_tx_data(txd1), .o_tx_valid(valid1), .i_tx_ready(tx_ready),
      .o_busy(busy1), .o_done(done1), .o_err(err1));

   memlog_dumper #(.BRAM_ADDR_WIDTH(4), .BRAM_DATA_WIDTH(16), .RD_LATENCY(2)) dut2 (
      .clk(clk), .i_rst(rst_n), .i_start(start2), .i_mem_full(mem_full),
      .o_read_log(read2), .o_addr_log_to_mem(addr2), .i_data_log_from_mem(rd2_q),
      .o_tx_data(txd2), .o_tx_valid(valid2), .i_tx_ready(tx_ready),
      .o_busy(busy2), .o_done(done2), .o_err(err2));

   // Log model: word[a] = A500 + a, one and two registered read stages.
   always @(posedge clk) begin
      rd1_q <= 16'hA500 + {12'h000, addr1};
      rd2_p <= 16'hA500 + {12'h000, addr2};
      rd2_q <= rd2_p;
   end

   logic       v_read, v_valid, v_busy, v_done, v_err;
   logic [3:0] v_addr;
   logic [7:0] v_data;
   assign v_read  = sel ? read2  : read1;
   assign v_valid = sel ? valid2 : valid1;
   assign v_busy  = sel ? busy2  : busy1;
   assign v_done  = sel ? done2  : done1;
   assign v_err   = sel ? err2   : err1;
   assign v_addr  = sel ? addr2  : addr1;
   assign v_data  = sel ? txd2   : txd1;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_read"},  32'(v_read),  0);
      check({tag, "_addr"},  32'(v_addr),  0);
      check({tag, "_data"},  32'(v_data),  0);
      check({tag, "_valid"}, 32'(v_valid), 0);
      check({tag, "_busy"},  32'(v_busy),  0);
      check({tag, "_done"},  32'(v_done),  0);
      check({tag, "_err"},   32'(v_err),   0);
   endtask

   typedef struct packed {
      logic rst_n, start, full, ready;
      logic busy, err, read, valid, done;
   } vec_t;

   vec_t vecs[10];

   task automatic run_dump(input int lat, input int ready_pct, input int abort_at,
                           input bit extra_start, input bit drop_full, input string tag);
      int got, cyc;
      bit hold, need_valid, aborted, found;
      logic [7:0] held, exp_b;
      got = 0; cyc = 0; hold = 0; need_valid = 0; aborted = 0; found = 0; held = '0;
      @(negedge clk);
      mem_full = 1'b1; start = 1'b1; tx_ready = 1'b0;
      @(negedge clk);                       // edge k has sampled the start
      start = 1'b0;
      if (drop_full) mem_full = 1'b0;
      check({tag, "_read_k1"}, 32'(v_read), 1);
      check({tag, "_busy_k1"}, 32'(v_busy), 1);
      check({tag, "_valid_k1"}, 32'(v_valid), 0);
      for (int j = 1; j <= 1 + lat; j++) begin
         @(negedge clk);
         check($sformatf("%s_read_k%0d", tag, j + 1), 32'(v_read), 0);
         check($sformatf("%s_valid_k%0d", tag, j + 1), 32'(v_valid), 0);
      end
      @(negedge clk);
      check({tag, "_first_valid"}, 32'(v_valid), 1);
      while (got < 32 && cyc < 1000 && !aborted) begin
         if (hold) begin
            check({tag, "_stall_valid"}, 32'(v_valid), 1);
            check({tag, "_stall_data"}, 32'(v_data), 32'(held));
         end
         if (need_valid) check({tag, "_no_bubble"}, 32'(v_valid), 1);
         if (v_err) check({tag, "_err_busy"}, 32'(v_err), 0);
         if (v_read) check({tag, "_read_busy"}, 32'(v_read), 0);
         if (extra_start) start = ((cyc % 7) == 3);
         tx_ready = ($urandom_range(99) < ready_pct);
         hold = v_valid && !tx_ready;
         held = v_data;
         need_valid = 1'b0;
         if (v_valid && tx_ready) begin
            exp_b = got[0] ? 8'(got >> 1) : 8'hA5;
            check($sformatf("%s_byte%0d", tag, got), 32'(v_data), 32'(exp_b));
            check($sformatf("%s_addr%0d", tag, got), 32'(v_addr), 32'(got >> 1));
            need_valid = !got[0];
            got++;
            if (abort_at != 0 && got == abort_at) begin
               @(posedge clk);
               #2 rst_n = 1'b0;
               #1 check_all_zero({tag, "_async"});
               aborted = 1'b1;
            end
         end
         if (!aborted) begin
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      tx_ready = 1'b0;
      if (aborted) begin
         repeat (3) @(negedge clk);
         check_all_zero({tag, "_held_rst"});
         rst_n = 1'b1;
         @(negedge clk);
         check({tag, "_idle_after_rst"}, 32'(v_busy), 0);
      end else begin
         check({tag, "_total_bytes"}, 32'(got), 32);
         for (int t = 0; t < 10 && !found; t++) begin
            if (v_done) found = 1'b1;
            else @(negedge clk);
         end
         check({tag, "_done_seen"}, 32'(found), 1);
         check({tag, "_busy_at_done"}, 32'(v_busy), 1);
         @(negedge clk);
         check({tag, "_done_once"}, 32'(v_done), 0);
         check({tag, "_busy_fall"}, 32'(v_busy), 0);
         check({tag, "_addr_back"}, 32'(v_addr), 0);
         check({tag, "_err_end"}, 32'(v_err), 0);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; mem_full = 1'b0; tx_ready = 1'b0; sel = 1'b0;

      //          rst st fl rdy  busy err read valid done
      vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         rst_n    = vecs[i].rst_n;
         start    = vecs[i].start;
         mem_full = vecs[i].full;
         tx_ready = vecs[i].ready;
         @(negedge clk);
         check($sformatf("vec%0d_busy", i),  32'(v_busy),  32'(vecs[i].busy));
         check($sformatf("vec%0d_err", i),   32'(v_err),   32'(vecs[i].err));
         check($sformatf("vec%0d_read", i),  32'(v_read),  32'(vecs[i].read));
         check($sformatf("vec%0d_valid", i), 32'(v_valid), 32'(vecs[i].valid));
         check($sformatf("vec%0d_done", i),  32'(v_done),  32'(vecs[i].done));
         check($sformatf("vec%0d_addr", i),  32'(v_addr),  0);
         check($sformatf("vec%0d_data", i),  32'(v_data),  0);
      end
      start = 1'b0; tx_ready = 1'b0;

      run_dump(1, 100, 0, 1'b0, 1'b0, "full");
      run_dump(1, 30,  0, 1'b0, 1'b1, "bp");
      run_dump(1, 100, 9, 1'b0, 1'b0, "abort");
      run_dump(1, 100, 0, 1'b0, 1'b0, "redump");
      run_dump(1, 50,  0, 1'b1, 1'b0, "busy_start");
      @(negedge clk);
      sel = 1'b1;
      run_dump(2, 100, 0, 1'b0, 1'b0, "lat2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
